pipe_stage_ctrl: RTL and testbench



---
 rtl/pipe_stage_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// Stall/flush/bubble controller for a chain of pipeline registers with a multi-cycle-op stall counter.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_stage_ctrl #(
  parameter int NSTAGE      = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int MC_STAGE    = 2,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              fetch_valid,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              flush_req,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_len,
  output logic [NSTAGE-1:0] stage_we,
  output logic [NSTAGE-1:0] stage_bubble,
  output logic [NSTAGE-1:0] stage_valid,
  output logic              mc_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [NSTAGE-1:0]   eff_stall_s;
  logic [NSTAGE-1:0]   hold_s;
  logic [NSTAGE-1:0]   we_s;
  logic [NSTAGE-1:0]   bubble_s;
  logic [NSTAGE-1:0]   valid_r;

  // State and counter register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r <= ST_RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; mc_start is only honoured from RUN
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (mc_start && (mc_len != CNT_ZERO)) begin
          state_nxt_s = ST_MC_BUSY;
          cnt_nxt_s   = mc_len;
        end else begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_MC_BUSY: begin
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_MC_BUSY;
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM output decode
  always_comb begin
    case (state_r)
      ST_MC_BUSY: mc_busy = 1'b1;
      ST_RUN:     mc_busy = 1'b0;
      default:    mc_busy = 1'b0;
    endcase
  end

  // Effective stall and downstream-to-upstream hold propagation
  always_comb begin
    logic acc;
    eff_stall_s = stall_req;
    if (cnt_r != CNT_ZERO) begin
      eff_stall_s[MC_STAGE] = 1'b1;
    end else begin
      eff_stall_s[MC_STAGE] = stall_req[MC_STAGE];
    end
    acc = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc       = acc | eff_stall_s[i];
      hold_s[i] = acc;
    end
  end

  // Write-enable and bubble select; flush overrides hold on the youngest registers
  always_comb begin
    bubble_s[0] = 1'b0;
    for (int i = 1; i < NSTAGE; i++) begin
      bubble_s[i] = hold_s[i-1] & ~hold_s[i];
    end
    we_s = ~hold_s | bubble_s;
    for (int i = 0; i < FLUSH_DEPTH; i++) begin
      if (flush_req) begin
        we_s[i]     = 1'b1;
        bubble_s[i] = 1'b1;
      end else begin
        we_s[i]     = we_s[i];
        bubble_s[i] = bubble_s[i];
      end
    end
  end

  // Outputs are forced low while reset is asserted
  always_comb begin
    if (areset) begin
      stage_we     = {NSTAGE{1'b0}};
      stage_bubble = {NSTAGE{1'b0}};
    end else begin
      stage_we     = we_s;
      stage_bubble = bubble_s;
    end
  end

  // Valid bit per pipeline register follows the data it tags
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_r <= {NSTAGE{1'b0}};
    end else begin
      if (we_s[0]) begin
        valid_r[0] <= bubble_s[0] ? 1'b0 : fetch_valid;
      end
      for (int i = 1; i < NSTAGE; i++) begin
        if (we_s[i]) begin
          valid_r[i] <= bubble_s[i] ? 1'b0 : valid_r[i-1];
        end
      end
    end
  end

  assign stage_valid = valid_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_r;
  logic [15:0] flush_count_r;

  // Saturating stall and flush event counters
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 16'd0;
    end else begin
      if ((|hold_s) && (stall_cycles_r != 32'hFFFF_FFFF)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
      if (flush_req && (flush_count_r != 16'hFFFF)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a queue-free behavioural model of the stall/flush rules.
module tb_pipe_stage_ctrl;

  localparam int NS = 4;
  localparam int FD = 2;
  localparam int MS = 2;

  logic          clk = 1'b0;
  logic          areset;
  logic          fetch_valid;
  logic [NS-1:0] stall_req;
  logic          flush_req;
  logic          mc_start;
  logic [3:0]    mc_len;
  logic [NS-1:0] stage_we;
  logic [NS-1:0] stage_bubble;
  logic [NS-1:0] stage_valid;
  logic          mc_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   flush_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [NS-1:0] m_valid;
  int            m_rem;

  pipe_stage_ctrl #(.NSTAGE(NS), .FLUSH_DEPTH(FD), .MC_STAGE(MS), .CNT_W(4)) dut (
    .clk          (clk),
    .areset       (areset),
    .fetch_valid  (fetch_valid),
    .stall_req    (stall_req),
    .flush_req    (flush_req),
    .mc_start     (mc_start),
    .mc_len       (mc_len),
    .stage_we     (stage_we),
    .stage_bubble (stage_bubble),
    .stage_valid  (stage_valid),
    .mc_busy      (mc_busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected {we, bubble}: everything at or below the oldest stalled index holds,
  // the register just above it takes a NOP, and a flush bubbles the young registers.
  function automatic logic [2*NS-1:0] exp_wb(input logic [NS-1:0] st, input logic fl,
                                             input int rem, input logic rst);
    logic [NS-1:0] we;
    logic [NS-1:0] bb;
    int top;
    we = '0;
    bb = '0;
    if (!rst) begin
      top = -1;
      for (int k = 0; k < NS; k++) begin
        if (st[k] || (k == MS && rem > 0)) top = k;
      end
      for (int i = 0; i < NS; i++) begin
        we[i] = (i > top);
        bb[i] = (top >= 0) && (i == top + 1);
        if (fl && i < FD) begin
          we[i] = 1'b1;
          bb[i] = 1'b1;
        end
      end
    end
    return {we, bb};
  endfunction

  function automatic logic [NS-1:0] next_valid(input logic [NS-1:0] v, input logic [2*NS-1:0] wb,
                                               input logic fv);
    logic [NS-1:0] n;
    n = v;
    for (int i = 0; i < NS; i++) begin
      if (wb[NS+i]) n[i] = wb[i] ? 1'b0 : ((i == 0) ? fv : v[i-1]);
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m_valid <= '0;
      m_rem   <= 0;
    end else begin
      m_valid <= next_valid(m_valid, exp_wb(stall_req, flush_req, m_rem, 1'b0), fetch_valid);
      if (m_rem > 0) m_rem <= m_rem - 1;
      else if (mc_start && mc_len != 4'd0) m_rem <= int'(mc_len);
    end
  end

  always @(negedge clk) begin
    chk("model_we",     stage_we,     exp_wb(stall_req, flush_req, m_rem, areset)[2*NS-1:NS]);
    chk("model_bubble", stage_bubble, exp_wb(stall_req, flush_req, m_rem, areset)[NS-1:0]);
    chk("model_valid",  stage_valid,  m_valid);
    chk("model_busy",   {3'b000, mc_busy}, {3'b000, m_rem > 0});
  end

  task automatic drive(input logic fv, input logic [NS-1:0] st, input logic fl,
                       input logic ms, input logic [3:0] ml);
    @(posedge clk);
    #1;
    fetch_valid = fv;
    stall_req   = st;
    flush_req   = fl;
    mc_start    = ms;
    mc_len      = ml;
  endtask

  initial begin
    logic [NS-1:0] fill_tab [4];
    fill_tab[0] = 4'b0001;
    fill_tab[1] = 4'b0011;
    fill_tab[2] = 4'b0111;
    fill_tab[3] = 4'b1111;
    areset = 1'b1; fetch_valid = 1'b0; stall_req = 4'b0000;
    flush_req = 1'b0; mc_start = 1'b0; mc_len = 4'd0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    repeat (5) drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);

    // 1: asynchronous reset mid-run, then fill
    @(posedge clk);
    #3 areset = 1'b1;
    #1;
    chk("rst_we",    stage_we,    4'b0000);
    chk("rst_valid", stage_valid, 4'b0000);
    chk("rst_bub",   stage_bubble, 4'b0000);
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("rel_valid", stage_valid, 4'b0000);
    chk("rel_we",    stage_we,    4'b1111);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("fill_valid", stage_valid, fill_tab[j]);
      chk("fill_we",    stage_we,    4'b1111);
    end

    // 2: single-cycle stall at register 2
    drive(1'b1, 4'b0100, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("st_we",  stage_we,     4'b1000);
    chk("st_bub", stage_bubble, 4'b1000);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("st_valid", stage_valid, 4'b0111);
    chk("st_we2",   stage_we,    4'b1111);
    repeat (2) drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);

    // 3: flush without stall
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    chk("fl_we",  stage_we,     4'b1111);
    chk("fl_bub", stage_bubble, 4'b0011);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("fl_valid", stage_valid, 4'b1100);
    repeat (4) drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);

    // 4: flush together with a stall at the oldest register
    drive(1'b1, 4'b1000, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    chk("fs_we",  stage_we,     4'b0011);
    chk("fs_bub", stage_bubble, 4'b0011);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("fs_valid", stage_valid, 4'b1100);
    repeat (4) drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);

    // 5: multi-cycle op of 3, with a re-start attempt while busy
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 4'd3);
    @(negedge clk);
    chk("mc_pre_busy", {3'b000, mc_busy}, 4'b0000);
    chk("mc_pre_we",   stage_we, 4'b1111);
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 4'b0000, 1'b0, (j == 0), 4'd5);
      @(negedge clk);
      chk("mc_busy", {3'b000, mc_busy}, 4'b0001);
      chk("mc_we",   stage_we,     4'b1000);
      chk("mc_bub",  stage_bubble, 4'b1000);
    end
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("mc_done_busy", {3'b000, mc_busy}, 4'b0000);
    chk("mc_done_we",   stage_we, 4'b1111);

    // 6: zero-length op is ignored; reset while busy
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 4'd0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("mc0_busy", {3'b000, mc_busy}, 4'b0000);
    chk("mc0_we",   stage_we, 4'b1111);
    drive(1'b1, 4'b0000, 1'b0, 1'b1, 4'd3);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    #2 areset = 1'b1;
    #1;
    chk("mcrst_busy", {3'b000, mc_busy}, 4'b0000);
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("mcrst_we", stage_we, 4'b1111);

    // Randomized traffic checked by the per-cycle model compare
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(1, 0)),
            4'($urandom_range(15, 0)) & 4'($urandom_range(15, 0)) & 4'($urandom_range(15, 0)),
            ($urandom_range(7, 0) == 0),
            ($urandom_range(9, 0) == 0),
            4'($urandom_range(15, 0)));
      areset = ($urandom_range(99, 0) == 0);
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);
    areset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
